// File: rtl/axi4lite_alu_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : axi4lite_alu_bank_if
// Brief   : AXI4-Lite bus bundle (AW/W/B/AR/R) for the ALU bank slave.
// Revision: 1.0 - initial release
// ============================================================================
interface axi4lite_alu_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              AW_VALID;
  logic              AW_READY;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              W_VALID;
  logic              W_READY;
  logic [DATA_W-1:0] W_DATA;
  logic              B_VALID;
  logic              B_READY;
  logic [1:0]        B_RESP;
  logic              AR_VALID;
  logic              AR_READY;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              R_VALID;
  logic              R_READY;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;

  modport slave (
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport master (
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface
`default_nettype wire

// File: rtl/axi4lite_alu_bank.sv
`default_nettype none
// ============================================================================
// Module  : axi4lite_alu_bank
// Brief   : AXI4-Lite calculator slave with operand/result registers, status
//           and an indexed memory bank. Define ALU_MUL_EN for opcode 10 MUL.
// Revision: 1.0 - initial release
// ============================================================================
module axi4lite_alu_bank #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int NUM_MEM = 8
) (
  input  logic                 A_CLK,
  input  logic                 A_RST,
  axi4lite_alu_bank_if.slave   bus
);

  localparam int LS = $clog2(DATA_W / 8);
  localparam int IW = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] MEM_BASE    = ADDR_W'(8'h40);
  localparam logic [2:0] REG_A      = 3'd0;
  localparam logic [2:0] REG_B      = 3'd1;
  localparam logic [2:0] REG_OP     = 3'd2;
  localparam logic [2:0] REG_RESULT = 3'd3;
  localparam logic [2:0] REG_SEL    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_EXEC  = 3'd1,
    W_EXEC2 = 3'd2,
    W_POST  = 3'd3,
    W_RESP  = 3'd4
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE    = 1'b0,
    R_DATA_ST = 1'b1
  } rstate_t;

  typedef struct packed {
    logic          ctl;
    logic          mem;
    logic [2:0]    word;
    logic [IW-1:0] idx;
  } dec_t;

  // Misaligned or unmapped addresses decode to neither ctl nor mem.
  function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
    dec_t              d;
    logic [ADDR_W-1:0] off;
    d   = '0;
    off = '0;
    if (addr[LS-1:0] == '0) begin
      if (addr < MEM_BASE) begin
        if ((addr >> LS) <= ADDR_W'(5)) begin
          d.ctl  = 1'b1;
          d.word = addr[LS+2:LS];
        end
      end else begin
        off = (addr - MEM_BASE) >> LS;
        if (off < ADDR_W'(NUM_MEM)) begin
          d.mem = 1'b1;
          d.idx = off[IW-1:0];
        end
      end
    end
    return d;
  endfunction

  wstate_t           wstate_q;
  rstate_t           rstate_q;
  logic              aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]        b_resp_q;
  logic              ar_ready_q, r_valid_q;
  logic [1:0]        r_resp_q;
  logic [DATA_W-1:0] r_data_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_q, b_q, op_q, result_q, sel_q;
  logic              carry_q, err_q;
  logic [DATA_W-1:0] mem_q [NUM_MEM];
`ifdef ALU_MUL_EN
  logic [DATA_W-1:0] mul_q;
`endif

  dec_t              wdec, rdec;
  logic              aw_have, w_have, busy, mem_ok, op_in_range, op_err, rd_err;
  logic [3:0]        op_code;
  logic [IW-1:0]     sel_idx;
  logic [DATA_W-1:0] rd_mux;

  assign wdec        = decode(waddr_q);
  assign rdec        = decode(bus.AR_ADDR);
  assign aw_have     = !aw_ready_q || bus.AW_VALID;
  assign w_have      = !w_ready_q  || bus.W_VALID;
  assign busy        = (wstate_q != W_IDLE);
  assign mem_ok      = (sel_q < DATA_W'(NUM_MEM));
  assign sel_idx     = sel_q[IW-1:0];
  assign op_code     = wdata_q[3:0];
  assign op_in_range = ((wdata_q >> 4) == '0);

  always_comb begin
    op_err = 1'b1;
    if (op_in_range) begin
      case (op_code)
        4'd0, 4'd1, 4'd2, 4'd8, 4'd9:       op_err = 1'b0;
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7:       op_err = !mem_ok;
`ifdef ALU_MUL_EN
        4'd10:                              op_err = 1'b0;
`endif
        default:                            op_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    rd_err = 1'b0;
    if (rdec.mem) begin
      rd_mux = mem_q[rdec.idx];
    end else if (rdec.ctl) begin
      case (rdec.word)
        REG_A:      rd_mux = a_q;
        REG_B:      rd_mux = b_q;
        REG_OP:     rd_mux = op_q;
        REG_RESULT: rd_mux = result_q;
        REG_SEL:    rd_mux = sel_q;
        REG_STATUS: rd_mux[2:0] = {err_q, carry_q, busy};
        default:    rd_err = 1'b1;
      endcase
    end else begin
      rd_err = 1'b1;
    end
  end

  // Write path: capture AW/W, commit in EXEC, one idle cycle, then respond.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      wstate_q   <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      waddr_q    <= '0;
      wdata_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      sel_q      <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_MEM; i++) mem_q[i] <= '0;
`ifdef ALU_MUL_EN
      mul_q      <= '0;
`endif
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (bus.AW_VALID && aw_ready_q) begin
            waddr_q    <= bus.AW_ADDR;
            aw_ready_q <= 1'b0;
          end
          if (bus.W_VALID && w_ready_q) begin
            wdata_q   <= bus.W_DATA;
            w_ready_q <= 1'b0;
          end
          if (aw_have && w_have) wstate_q <= W_EXEC;
        end
        W_EXEC: begin
          wstate_q <= W_POST;
          b_resp_q <= RESP_OKAY;
          if (wdec.mem) begin
            mem_q[wdec.idx] <= wdata_q;
          end else if (!wdec.ctl) begin
            b_resp_q <= RESP_SLVERR;
          end else begin
            case (wdec.word)
              REG_A:      a_q      <= wdata_q;
              REG_B:      b_q      <= wdata_q;
              REG_RESULT: result_q <= wdata_q;
              REG_SEL:    sel_q    <= wdata_q;
              REG_STATUS: if (wdata_q[2]) err_q <= 1'b0;
              REG_OP: begin
                op_q <= wdata_q;
                if (op_err) begin
                  b_resp_q <= RESP_SLVERR;
                  err_q    <= 1'b1;
                end else begin
                  case (op_code)
                    4'd0: {carry_q, result_q} <= {1'b0, a_q} + {1'b0, b_q};
                    4'd1: result_q <= a_q & b_q;
                    4'd2: result_q <= a_q | b_q;
                    4'd3: a_q <= mem_q[sel_idx];
                    4'd4: mem_q[sel_idx] <= mem_q[sel_idx] + result_q;
                    4'd5: mem_q[sel_idx] <= mem_q[sel_idx] - result_q;
                    4'd6: result_q <= mem_q[sel_idx];
                    4'd7: mem_q[sel_idx] <= '0;
                    4'd8: {carry_q, result_q} <= {1'b0, a_q} - {1'b0, b_q};
                    4'd9: result_q <= a_q ^ b_q;
`ifdef ALU_MUL_EN
                    4'd10: begin
                      mul_q    <= a_q * b_q;
                      wstate_q <= W_EXEC2;
                    end
`endif
                    default: ;
                  endcase
                end
              end
              default: ;
            endcase
          end
        end
`ifdef ALU_MUL_EN
        W_EXEC2: begin
          result_q <= mul_q;
          wstate_q <= W_POST;
        end
`endif
        W_POST: begin
          b_valid_q <= 1'b1;
          wstate_q  <= W_RESP;
        end
        W_RESP: begin
          if (bus.B_READY) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            wstate_q   <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read path: data is latched at the AR handshake and held while stalled.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      rstate_q   <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (bus.AR_VALID) begin
            r_data_q   <= rd_mux;
            r_resp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            rstate_q   <= R_DATA_ST;
          end
        end
        R_DATA_ST: begin
          if (bus.R_READY) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            rstate_q   <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign bus.AW_READY = aw_ready_q;
  assign bus.W_READY  = w_ready_q;
  assign bus.B_VALID  = b_valid_q;
  assign bus.B_RESP   = b_resp_q;
  assign bus.AR_READY = ar_ready_q;
  assign bus.R_VALID  = r_valid_q;
  assign bus.R_DATA   = r_data_q;
  assign bus.R_RESP   = r_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_alu_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4lite_alu_bank
// Brief   : Directed self-checking bench for axi4lite_alu_bank (32-bit, 8 mems).
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi4lite_alu_bank;
  localparam logic [7:0] A_A = 8'h00, A_B = 8'h04, A_OP = 8'h08, A_RES = 8'h0C;
  localparam logic [7:0] A_SEL = 8'h10, A_ST = 8'h14;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  axi4lite_alu_bank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axi4lite_alu_bank #(.DATA_W(32), .ADDR_W(8), .NUM_MEM(8)) dut (
    .A_CLK (clk),
    .A_RST (rst),
    .bus   (bus)
  );

  // Bus drivers; callers enter #1 after a rising edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
    logic aw_hs, w_hs, b_hs, done;
    done = 1'b0;
    resp = 2'b11;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = addr;
    bus.W_VALID  = 1'b1; bus.W_DATA  = data;
    bus.B_READY  = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      aw_hs = bus.AW_VALID && bus.AW_READY;
      w_hs  = bus.W_VALID && bus.W_READY;
      b_hs  = bus.B_VALID && bus.B_READY;
      if (b_hs) resp = bus.B_RESP;
      @(posedge clk); #1;
      if (aw_hs) bus.AW_VALID = 1'b0;
      if (w_hs)  bus.W_VALID  = 1'b0;
      if (b_hs) begin bus.B_READY = 1'b0; done = 1'b1; end
    end
    if (!done) begin
      n_total++;
      $display("FAIL write_timeout addr=%0h: no B handshake, required within 40 cycles", addr);
      bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.B_READY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic ar_hs, r_hs, done;
    done = 1'b0;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = addr; bus.R_READY = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      ar_hs = bus.AR_VALID && bus.AR_READY;
      r_hs  = bus.R_VALID && bus.R_READY;
      if (r_hs) begin data = bus.R_DATA; resp = bus.R_RESP; end
      @(posedge clk); #1;
      if (ar_hs) bus.AR_VALID = 1'b0;
      if (r_hs) begin bus.R_READY = 1'b0; done = 1'b1; end
    end
    if (!done) begin
      n_total++;
      $display("FAIL read_timeout addr=%0h: no R handshake, required within 40 cycles", addr);
      bus.AR_VALID = 1'b0; bus.R_READY = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic [1:0] rr;
    logic [7:0] addrs [7] = '{A_A, A_B, A_OP, A_RES, A_SEL, A_ST, 8'h40};
    bus.AW_VALID = 0; bus.AW_ADDR = 0; bus.W_VALID = 0; bus.W_DATA = 0; bus.B_READY = 0;
    bus.AR_VALID = 0; bus.AR_ADDR = 0; bus.R_READY = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_total++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID} !== 5'b11100 ||
        bus.B_RESP !== 2'b00 || bus.R_RESP !== 2'b00 || bus.R_DATA !== 32'h0)
      $display("FAIL reset_outputs: rdy/valid=%b bresp=%b rresp=%b rdata=%0h, required 11100 00 00 0",
               {bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID},
               bus.B_RESP, bus.R_RESP, bus.R_DATA);
    else n_pass++;
    foreach (addrs[i]) begin
      axi_read(addrs[i], rd, rr);
      n_total++;
      if (rd !== 32'h0 || rr !== OKAY)
        $display("FAIL reset_reg addr=%0h: data=%0h resp=%b, required 0 OKAY", addrs[i], rd, rr);
      else n_pass++;
    end
  endtask

  task automatic test_alu_basic();
    logic [31:0] rd; logic [1:0] rr, br;
    logic [31:0] ops [4] = '{32'd0, 32'd1, 32'd2, 32'd9};
    logic [31:0] exp [4] = '{32'd60, 32'd2, 32'd58, 32'd56};
    axi_write(A_A, 32'd50, br);
    axi_write(A_B, 32'd10, br);
    foreach (ops[i]) begin
      axi_write(A_OP, ops[i], br);
      axi_read(A_RES, rd, rr);
      n_total++;
      if (rd !== exp[i] || rr !== OKAY || br !== OKAY)
        $display("FAIL alu_op%0d: result=%0d resp=%b bresp=%b, required %0d OKAY OKAY", ops[i], rd, rr, br, exp[i]);
      else n_pass++;
    end
    axi_read(A_ST, rd, rr);
    n_total++;
    if (rd !== 32'h0) $display("FAIL alu_status: got %0h, required 0", rd); else n_pass++;
    axi_read(A_OP, rd, rr);
    n_total++;
    if (rd !== 32'd9) $display("FAIL opcode_readback: got %0d, required 9", rd); else n_pass++;
  endtask

  task automatic test_carry();
    logic [31:0] rd, st; logic [1:0] rr, br;
    axi_write(A_A, 32'hFFFF_FFFF, br);
    axi_write(A_B, 32'd1, br);
    axi_write(A_OP, 32'd0, br);
    axi_read(A_RES, rd, rr);
    axi_read(A_ST, st, rr);
    n_total++;
    if (rd !== 32'h0 || st !== 32'h2) $display("FAIL add_carry: result=%0h status=%0h, required 0 2", rd, st);
    else n_pass++;
    axi_write(A_A, 32'd3, br);
    axi_write(A_B, 32'd5, br);
    axi_write(A_OP, 32'd8, br);
    axi_read(A_RES, rd, rr);
    axi_read(A_ST, st, rr);
    n_total++;
    if (rd !== 32'hFFFF_FFFE || st !== 32'h2) $display("FAIL sub_borrow: result=%0h status=%0h, required fffffffe 2", rd, st);
    else n_pass++;
    axi_write(A_OP, 32'd1, br);
    axi_read(A_RES, rd, rr);
    axi_read(A_ST, st, rr);
    n_total++;
    if (rd !== 32'd1 || st !== 32'h2) $display("FAIL and_keeps_carry: result=%0h status=%0h, required 1 2", rd, st);
    else n_pass++;
  endtask

  task automatic test_mem_ops();
    logic [31:0] rd; logic [1:0] rr, br;
    axi_write(8'h54, 32'd10, br);
    axi_write(A_A, 32'd5, br);
    axi_write(A_B, 32'd0, br);
    axi_write(A_OP, 32'd0, br);
    axi_write(A_SEL, 32'd5, br);
    axi_write(A_OP, 32'd4, br);
    axi_read(8'h54, rd, rr);
    n_total++;
    if (rd !== 32'd15 || br !== OKAY) $display("FAIL mem_plus: mem5=%0d bresp=%b, required 15 OKAY", rd, br); else n_pass++;
    axi_write(A_A, 32'd3, br);
    axi_write(A_OP, 32'd0, br);
    axi_write(A_OP, 32'd5, br);
    axi_read(8'h54, rd, rr);
    n_total++;
    if (rd !== 32'd12) $display("FAIL mem_minus: mem5=%0d, required 12", rd); else n_pass++;
    axi_write(A_OP, 32'd6, br);
    axi_read(A_RES, rd, rr);
    n_total++;
    if (rd !== 32'd12) $display("FAIL mem_recall: result=%0d, required 12", rd); else n_pass++;
    axi_write(A_OP, 32'd7, br);
    axi_read(8'h54, rd, rr);
    n_total++;
    if (rd !== 32'd0) $display("FAIL mem_clear: mem5=%0d, required 0", rd); else n_pass++;
    axi_write(8'h58, 32'd42, br);
    axi_write(A_SEL, 32'd6, br);
    axi_write(A_OP, 32'd3, br);
    axi_read(A_A, rd, rr);
    n_total++;
    if (rd !== 32'd42) $display("FAIL load_a: a=%0d, required 42", rd); else n_pass++;
    axi_write(A_B, 32'd18, br);
    axi_write(A_OP, 32'd0, br);
    axi_read(A_RES, rd, rr);
    n_total++;
    if (rd !== 32'd60) $display("FAIL load_a_add: result=%0d, required 60", rd); else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] rd, m0, m5, m6, op; logic [1:0] rr, br;
    axi_write(A_SEL, 32'd8, br);
    axi_write(A_OP, 32'd4, br);
    axi_read(A_ST, rd, rr);
    n_total++;
    if (br !== SLVERR || rd !== 32'h4) $display("FAIL sel_range: bresp=%b status=%0h, required 10 4", br, rd); else n_pass++;
    axi_read(8'h40, m0, rr);
    axi_read(8'h54, m5, rr);
    axi_read(8'h58, m6, rr);
    axi_read(A_OP, op, rr);
    n_total++;
    if (m0 !== 32'd0 || m5 !== 32'd0 || m6 !== 32'd42 || op !== 32'd4)
      $display("FAIL sel_range_nochange: m0=%0d m5=%0d m6=%0d op=%0d, required 0 0 42 4", m0, m5, m6, op);
    else n_pass++;
    axi_write(A_ST, 32'h4, br);
    axi_read(A_ST, rd, rr);
    n_total++;
    if (br !== OKAY || rd !== 32'h0) $display("FAIL err_clear: bresp=%b status=%0h, required 00 0", br, rd); else n_pass++;
    axi_read(8'h3C, rd, rr);
    n_total++;
    if (rr !== SLVERR || rd !== 32'h0) $display("FAIL read_unmapped: resp=%b data=%0h, required 10 0", rr, rd); else n_pass++;
    axi_read(8'h60, rd, rr);
    n_total++;
    if (rr !== SLVERR || rd !== 32'h0) $display("FAIL read_past_bank: resp=%b data=%0h, required 10 0", rr, rd); else n_pass++;
    axi_write(8'h3C, 32'h1234, br);
    axi_read(A_RES, rd, rr);
    n_total++;
    if (br !== SLVERR || rd !== 32'd60) $display("FAIL write_unmapped: bresp=%b result=%0d, required 10 60", br, rd); else n_pass++;
    axi_write(A_OP, 32'd11, br);
    axi_read(A_ST, rd, rr);
    n_total++;
    if (br !== SLVERR || rd !== 32'h4) $display("FAIL undef_op: bresp=%b status=%0h, required 10 4", br, rd); else n_pass++;
    axi_write(A_ST, 32'h4, br);
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic [1:0] rr, br;
    logic        ok;
    int          n;
    bus.W_VALID = 1'b1; bus.W_DATA = 32'h77; bus.B_READY = 1'b0;
    @(posedge clk); #1;
    bus.W_VALID = 1'b0;
    n_total++;
    if (bus.W_READY !== 1'b0 || bus.AW_READY !== 1'b1)
      $display("FAIL w_first_ready: wready=%b awready=%b, required 0 1", bus.W_READY, bus.AW_READY);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 bus.AW_VALID = 1'b1; bus.AW_ADDR = A_A;
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0;
    n = 0;
    while (!bus.B_VALID && n < 10) begin @(posedge clk); #1; n++; end
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (bus.B_VALID !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    n_total++;
    if (!ok || bus.B_VALID !== 1'b1) $display("FAIL b_hold: bvalid dropped while stalled (n=%0d), required held 1", n); else n_pass++;
    axi_read(A_ST, rd, rr);
    br = bus.B_RESP;
    n_total++;
    if (rd[0] !== 1'b1 || br !== OKAY) $display("FAIL busy_during_b: status=%0h bresp=%b, required bit0=1 00", rd, br); else n_pass++;
    bus.B_READY = 1'b1;
    @(posedge clk); #1;
    bus.B_READY = 1'b0;
    axi_read(A_ST, rd, rr);
    n_total++;
    if (bus.B_VALID !== 1'b0 || bus.AW_READY !== 1'b1 || bus.W_READY !== 1'b1 || rd[0] !== 1'b0)
      $display("FAIL b_release: bvalid=%b awready=%b wready=%b status=%0h, required 0 1 1 busy0",
               bus.B_VALID, bus.AW_READY, bus.W_READY, rd);
    else n_pass++;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = A_A; bus.R_READY = 1'b0;
    @(posedge clk); #1;
    bus.AR_VALID = 1'b0;
    axi_write(A_A, 32'h88, br);
    ok = (bus.R_VALID === 1'b1 && bus.R_DATA === 32'h77);
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.R_VALID !== 1'b1 || bus.R_DATA !== 32'h77) ok = 1'b0;
    end
    n_total++;
    if (!ok) $display("FAIL r_stall: rvalid=%b rdata=%0h, required 1 77 held", bus.R_VALID, bus.R_DATA); else n_pass++;
    bus.R_READY = 1'b1;
    @(posedge clk); #1;
    bus.R_READY = 1'b0;
    axi_read(A_A, rd, rr);
    n_total++;
    if (bus.R_VALID !== 1'b0 || rd !== 32'h88) $display("FAIL r_after_stall: rvalid=%b a=%0h, required 0 88", bus.R_VALID, rd); else n_pass++;
  endtask

  task automatic test_mul();
    logic [31:0] rd, st; logic [1:0] rr, br;
    int          n;
    axi_write(A_A, 32'd7, br);
    axi_write(A_B, 32'd6, br);
    axi_write(A_OP, 32'd0, br);
    bus.AW_VALID = 1'b1; bus.AW_ADDR = A_OP; bus.W_VALID = 1'b1; bus.W_DATA = 32'd10; bus.B_READY = 1'b0;
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    n = 0;
    while (!bus.B_VALID && n < 10) begin @(posedge clk); #1; n++; end
    br = bus.B_RESP;
    bus.B_READY = 1'b1;
    @(posedge clk); #1;
    bus.B_READY = 1'b0;
    axi_read(A_RES, rd, rr);
    axi_read(A_ST, st, rr);
`ifdef ALU_MUL_EN
    n_total++;
    if (n !== 3) $display("FAIL mul_latency: bvalid after %0d cycles, required 3", n); else n_pass++;
    n_total++;
    if (br !== OKAY || rd !== 32'd42 || st !== 32'h0)
      $display("FAIL mul_result: bresp=%b result=%0d status=%0h, required 00 42 0", br, rd, st);
    else n_pass++;
`else
    n_total++;
    if (n >= 10 || br !== SLVERR || rd !== 32'd13 || st !== 32'h4)
      $display("FAIL mul_disabled: bresp=%b result=%0d status=%0h, required 10 13 4", br, rd, st);
    else n_pass++;
`endif
    axi_write(A_ST, 32'h4, br);
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd; logic [1:0] rr;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = A_B; bus.W_VALID = 1'b1; bus.W_DATA = 32'h99; bus.B_READY = 1'b0;
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (bus.B_VALID !== 1'b0 || bus.AW_READY !== 1'b1 || bus.W_READY !== 1'b1)
      $display("FAIL mid_reset_bus: bvalid=%b awready=%b wready=%b, required 0 1 1", bus.B_VALID, bus.AW_READY, bus.W_READY);
    else n_pass++;
    axi_read(A_B, rd, rr);
    n_total++;
    if (rd !== 32'h0) $display("FAIL mid_reset_commit: b=%0h, required 0", rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_carry();
    test_mem_ops();
    test_errors();
    test_stall();
    test_mul();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4lite_alu_bank.md
# axi4lite_alu_bank

Parametrised AXI4-Lite slave calculator: operand registers, opcode-triggered ALU, result register and an indexed memory-register bank with M+/M-/MR/MC/LOAD_A operations. It generalises the calculator slave to configurable data width and bank depth. It adds a status register, error responses and an optional pipelined multiplier. It sits directly behind the AXI4-Lite master (VIP or interconnect port) on the shared clock.

## Interface
- DATA_W, 32: data and register width, 32 or 64; register stride S = DATA_W/8 bytes.
- ADDR_W, 8: AW_ADDR/AR_ADDR width.
- NUM_MEM, 8: memory-bank entries, 1..16.
- A_CLK  in  1  clock; all logic on rising edge.
- A_RST  in  1  synchronous, active-high reset.
- AW_VALID in 1 / AW_READY out 1 / AW_ADDR in ADDR_W: write-address channel.
- W_VALID in 1 / W_READY out 1 / W_DATA in DATA_W: write-data channel; no strobes, full-word writes only.
- B_VALID out 1 / B_READY in 1 / B_RESP out 2: write response, 00 OKAY, 10 SLVERR.
- AR_VALID in 1 / AR_READY out 1 / AR_ADDR in ADDR_W: read-address channel.
- R_VALID out 1 / R_READY in 1 / R_DATA out DATA_W / R_RESP out 2: read-data channel.

## Operation
- Register map, as word index × S:
  - 0 A
  - 1 B
  - 2 OPCODE: write triggers execution; read returns last accepted opcode.
  - 3 RESULT
  - 4 MEM_SEL
  - 5 STATUS: bit0 BUSY, bit1 CARRY, bit2 ERR (sticky; write with bit2=1 clears, other bits ignored).
  - 0x40 + i×S: MEM[i], i < NUM_MEM.
- Any other address: write → SLVERR, no state change; read → SLVERR, R_DATA = 0.
- Opcodes, DATA_W-bit arithmetic wrapping mod 2^DATA_W:
  - 0 ADD: RESULT=A+B, CARRY=carry-out.
  - 1 AND: RESULT=A&B.
  - 2 OR: RESULT=A|B.
  - 3 LOAD_A: A=MEM[sel].
  - 4 M+: MEM[sel]+=RESULT.
  - 5 M-: MEM[sel]-=RESULT.
  - 6 MR: RESULT=MEM[sel].
  - 7 MC: MEM[sel]=0.
  - 8 SUB: RESULT=A-B, CARRY=borrow.
  - 9 XOR: RESULT=A^B.
  - 10 MUL: see Configuration.
- CARRY is updated only by ADD/SUB.
- Opcodes 3–7 with MEM_SEL ≥ NUM_MEM, and any undefined opcode: SLVERR, ERR set, no register change; OPCODE register is still updated.
- Write FSM states:
  - W_IDLE: AW and W captured independently, in either order or the same cycle; each READY drops after its own capture.
  - EXEC: one cycle, MUL two.
  - RESP: B_VALID held until B_READY.
  - Returns to W_IDLE.
- Read FSM states: R_IDLE (AR_READY=1), then R_DATA_ST (R_VALID held until R_READY).
- Read and write paths are independent.

## Timing
- Reset: all registers 0, OPCODE 0, both FSMs idle. AW_READY, W_READY, AR_READY = 1; B_VALID, R_VALID = 0; B_RESP, R_RESP, R_DATA = 0.
- Write: commit in the EXEC cycle after both AW and W are captured. B_VALID rises the cycle after commit, so a read issued after the B handshake always sees the new value.
- AW_READY and W_READY stay low from capture until the B handshake completes.
- BUSY=1 from capture of both AW and W until the B handshake.
- Read: R_VALID one cycle after the AR handshake. R_DATA is sampled at the AR handshake and holds stable while stalled.
- Same-cycle read and write commit to the same register: the read returns the old value.
- Reset asserted mid-transaction aborts it: VALIDs drop next edge, no partial commit.

## Configuration
- ALU_MUL_EN defined: opcode 10 MUL, RESULT = low DATA_W bits of A×B, two-cycle EXEC; B_VALID three cycles after capture; CARRY unchanged.
- ALU_MUL_EN undefined: opcode 10 is undefined → SLVERR, ERR set; no multiplier logic.

## Test plan
- Write A=50, B=10, OP=0; read RESULT → 60, OKAY, CARRY=0. Then OP=1 → RESULT 2.
- A=0xFFFFFFFF, B=1, OP=0 → RESULT 0, STATUS=0x2. Then A=3, B=5, OP=8 → RESULT 0xFFFFFFFE, CARRY=1.
- MEM[5]=10; RESULT set to 5 via ADD 5+0; MEM_SEL=5, OP=4 → MEM[5]=15. RESULT=3, OP=5 → 12. OP=6 → RESULT 12. OP=7 → MEM[5]=0. MEM[6]=42, MEM_SEL=6, OP=3, B=18, OP=0 → RESULT 60.
- MEM_SEL=NUM_MEM, OP=4 → SLVERR, STATUS bit2=1, bank unchanged. Write STATUS=0x4 → ERR cleared. Read address 0x3C → SLVERR, data 0.
- W before AW by 3 cycles, with B_READY held low for 5 cycles → single commit, B_VALID held, BUSY=1 throughout. R_READY stalled 4 cycles → R_DATA stable.
- With ALU_MUL_EN: A=7, B=6, OP=10 → RESULT 42, B_VALID three cycles after capture. Without ALU_MUL_EN: same stimulus → SLVERR.
